// File: rtl/cond_flags_gen.sv
// cond_flags_gen
//   Multi-cycle magnitude comparator. It produces a one-hot lt/eq/gt flag
//   triple for the ALU condition checker. Operands are compared MSB-first,
//   DIGIT bits per cycle. The scan stops at the first digit that differs.
//   BUS_WIDTH must be an integer multiple of DIGIT.
//
// Parameters
//   BUS_WIDTH  operand width in bits
//   DIGIT      bits examined per cycle
//   SIGNED     1 = two's-complement compare, 0 = unsigned compare
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands a/b valid
//   in_ready   operands can be accepted (high only while idle)
//   a, b       operands
//   out_valid  lt/eq/gt hold a fresh result
//   out_ready  consumer accepts the result
//   busy       scan in progress or result pending
//   lt/eq/gt   a < b, a == b, a > b. They hold their value until the next
//              result replaces them.
module cond_flags_gen #(
  parameter int BUS_WIDTH = 8,
  parameter int DIGIT     = 1,
  parameter int SIGNED    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 lt,
  output logic                 eq,
  output logic                 gt
);

  localparam int N  = BUS_WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  // The scan itself can then always be an unsigned compare.
  localparam logic [BUS_WIDTH-1:0] MSB_FLIP =
    (SIGNED != 0) ? (BUS_WIDTH'(1) << (BUS_WIDTH - 1)) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t               state;
  logic [BUS_WIDTH-1:0] sh_a;
  logic [BUS_WIDTH-1:0] sh_b;
  logic [CW-1:0]        cnt;
  logic [DIGIT-1:0]     dig_a;
  logic [DIGIT-1:0]     dig_b;

  always_comb begin
    dig_a = sh_a[BUS_WIDTH-1 -: DIGIT];
    dig_b = sh_b[BUS_WIDTH-1 -: DIGIT];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      sh_a      <= '0;
      sh_b      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sh_a     <= a ^ MSB_FLIP;
            sh_b     <= b ^ MSB_FLIP;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (dig_a != dig_b) begin
            lt        <= (dig_a < dig_b);
            gt        <= (dig_a > dig_b);
            eq        <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == CW'(N - 1)) begin
            lt        <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_flags_gen.sv
// Testbench for cond_flags_gen. Three instances share one stimulus stream:
//   d0: DIGIT=1, SIGNED=1   d1: DIGIT=1, SIGNED=0   d2: DIGIT=4, SIGNED=1
module tb_cond_flags_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] ir;
  logic [2:0] ov;
  logic [2:0] bz;
  logic [2:0] lt_o;
  logic [2:0] eq_o;
  logic [2:0] gt_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cond_flags_gen #(.BUS_WIDTH(8), .DIGIT(1), .SIGNED(1)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]),
    .lt(lt_o[0]), .eq(eq_o[0]), .gt(gt_o[0]));

  cond_flags_gen #(.BUS_WIDTH(8), .DIGIT(1), .SIGNED(0)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]),
    .lt(lt_o[1]), .eq(eq_o[1]), .gt(gt_o[1]));

  cond_flags_gen #(.BUS_WIDTH(8), .DIGIT(4), .SIGNED(1)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .out_valid(ov[2]), .out_ready(out_ready), .busy(bz[2]),
    .lt(lt_o[2]), .eq(eq_o[2]), .gt(gt_o[2]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. It compares the operands as integers and finds the
  // 1-based index of the first differing DIGIT-wide group of a^b, MSB first.
  function automatic void model(input int idx, input logic [7:0] av,
                                input logic [7:0] bv, output logic [2:0] fl,
                                output int k);
    int dg;
    int sa;
    int sb;
    int x;
    bit found;
    dg    = (idx == 2) ? 4 : 1;
    sa    = (idx != 1) ? int'($signed(av)) : int'(av);
    sb    = (idx != 1) ? int'($signed(bv)) : int'(bv);
    fl    = {sa < sb, sa == sb, sa > sb};
    x     = int'(av ^ bv);
    k     = 8 / dg;
    found = 0;
    for (int i = 0; i < 8 / dg; i++) begin
      if (!found && (((x >> (8 - (i + 1) * dg)) & ((1 << dg) - 1)) != 0)) begin
        k     = i + 1;
        found = 1;
      end
    end
  endfunction

  task automatic wait_ready();
    int c;
    c = 0;
    while (ir !== 3'b111 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    if (ir !== 3'b111) chk("ready_timeout", int'(ir), 7);
  endtask

  // Call this right after the accepting edge. out_ready must be high.
  task automatic collect(input logic [7:0] av, input logic [7:0] bv);
    bit [2:0] seen;
    int       lat[3];
    logic [2:0] fl[3];
    logic [2:0] efl;
    int       k;
    seen = '0;
    for (int c = 1; c <= 20 && seen != 3'b111; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && !seen[i]) begin
          seen[i] = 1'b1;
          lat[i]  = c;
          fl[i]   = {lt_o[i], eq_o[i], gt_o[i]};
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      model(i, av, bv, efl, k);
      if (!seen[i]) begin
        chk($sformatf("d%0d_timeout a=%0h b=%0h", i, av, bv), 0, 1);
      end else begin
        chk($sformatf("d%0d_latency a=%0h b=%0h", i, av, bv), lat[i], k);
        chk($sformatf("d%0d_flags a=%0h b=%0h", i, av, bv), int'(fl[i]), int'(efl));
      end
    end
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv);
    wait_ready();
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect(av, bv);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_d%0d_in_ready", tag, i), int'(ir[i]), 1);
      chk($sformatf("%s_d%0d_out_valid", tag, i), int'(ov[i]), 0);
      chk($sformatf("%s_d%0d_busy", tag, i), int'(bz[i]), 0);
      chk($sformatf("%s_d%0d_flags", tag, i), int'({lt_o[i], eq_o[i], gt_o[i]}), 0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // Directed operations.
    run_op(8'd20, 8'd0);
    run_op(8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("eq_held_after_handshake", int'({lt_o[0], eq_o[0], gt_o[0]}), 3'b010);
    run_op(8'd130, 8'd0);
    run_op(8'h5A, 8'h5A);
    run_op(8'h7F, 8'h80);
    run_op(8'h80, 8'h7F);
    run_op(8'hFF, 8'h00);
    run_op(8'h01, 8'h00);

    // Backpressure: hold the result in DONE and present an operand pair
    // that must be ignored.
    wait_ready();
    a = 8'd20; b = 8'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 8'd0; b = 8'd5;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 3) chk("bp_early_valid", int'(ov[0]), 0);
    end
    chk("bp_latency_valid", int'(ov[0]), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", int'(ov[0]), 1);
      chk("bp_flags", int'({lt_o[0], eq_o[0], gt_o[0]}), 3'b001);
      chk("bp_in_ready", int'(ir[0]), 0);
      chk("bp_busy", int'(bz[0]), 1);
      chk("bp_d2_flags", int'({ov[2], lt_o[2], eq_o[2], gt_o[2]}), 4'b1001);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", int'(ov[0]), 0);
    chk("bp_release_in_ready", int'(ir[0]), 1);
    @(posedge clk); #1;
    chk("bp_reaccept_in_ready", int'(ir[0]), 0);
    chk("bp_reaccept_busy", int'(bz[0]), 1);
    in_valid = 1'b0;
    collect(8'd0, 8'd5);

    // Reset in the third SCAN cycle of a=0, b=0.
    wait_ready();
    a = 8'd0; b = 8'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("scan_busy", int'(bz[0]), 1);
    chk("scan_out_valid", int'(ov[0]), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("midscan_reset");
    rst = 1'b0;
    run_op(8'd0, 8'd0);
    run_op(8'd20, 8'd0);

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      run_op(ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
